sdram_line_fill_sequencer: RTL and testbench

// Line-fill engine between the SDRAM controller read port and the line cache.

---
 rtl/sdram_fill_pkg.sv | 14 +
 rtl/sdram_line_fill_sequencer_if.sv | 41 ++++
 rtl/sdram_fill_fifo.sv | 57 +++++
 rtl/sdram_line_fill_sequencer.sv | 122 ++++++++++++
 tb/tb_sdram_line_fill_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_fill_pkg.sv
// Shared types and default sizes for the SDRAM line-fill sequencer.
package sdram_fill_pkg;

  localparam int DEF_LINE_WORDS = 64;
  localparam int DEF_ADDR_W     = 25;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fill_state_t;

endpackage

// File: rtl/sdram_line_fill_sequencer_if.sv
// Cache-side fill handshake plus SDRAM read port. The master modport is the sequencer;
// the slave modport is the environment, which is the cache together with the controller.
interface sdram_line_fill_sequencer_if
  import sdram_fill_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W
) ();

  localparam int IDX_W = $clog2(LINE_WORDS);

  logic              fill_req;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_abort;
  logic              fill_ready;
  logic              fill_valid;
  logic              fill_take;
  logic [15:0]       fill_data;
  logic [IDX_W-1:0]  fill_index;
  logic              fill_last;
  logic              fill_done;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [15:0]       mem_rdata;
  logic              err;

  modport master (
    input  fill_req, fill_addr, fill_abort, fill_take, mem_ack, mem_rvalid, mem_rdata,
    output fill_ready, fill_valid, fill_data, fill_index, fill_last, fill_done,
           mem_req, mem_addr, err
  );

  modport slave (
    output fill_req, fill_addr, fill_abort, fill_take, mem_ack, mem_rvalid, mem_rdata,
    input  fill_ready, fill_valid, fill_data, fill_index, fill_last, fill_done,
           mem_req, mem_addr, err
  );

endinterface

// File: rtl/sdram_fill_fifo.sv
// Synchronous show-ahead FIFO with flush. The head entry is visible on rdata whenever it is
// not empty. A push while full is accepted only when it is paired with a pop.
module sdram_fill_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // NOTE: storage has no reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sdram_line_fill_sequencer.sv
// Line-fill engine: issues LINE_WORDS single-word SDRAM reads for one cache line.
// Read credits bound the in-flight reads plus the buffered words to FIFO_DEPTH.
module sdram_line_fill_sequencer
  import sdram_fill_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  sdram_line_fill_sequencer_if.master    bus
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int EW    = 16 + IDX_W;

  fill_state_t       state, state_nxt;
  logic [ADDR_W-1:0] base_addr;
  logic [IDX_W:0]    issue_idx;
  logic [IDX_W-1:0]  ret_idx;
  logic [CW-1:0]     outstanding, outstanding_nxt, fifo_count;
  logic [CW:0]       credit_used;
  logic [EW-1:0]     head;
  logic [15:0]       head_data;
  logic [IDX_W-1:0]  head_idx;
  logic              fifo_empty, fill_done_q, err_q;
  logic              accept, acked, rv_ok, rv_stray, push, pop, pop_last, abort_run, flush;

  assign {head_data, head_idx} = head;

  assign accept    = (state == IDLE) && bus.fill_req;
  assign abort_run = (state == RUN) && bus.fill_abort;
  assign flush     = accept || abort_run;

  // issue_idx carries one extra bit, so its MSB alone means every word of the line was issued.
  assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign bus.mem_req  = (state == RUN) && !issue_idx[IDX_W] && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign bus.mem_addr = base_addr | ADDR_W'(issue_idx[IDX_W-1:0]);

  assign acked    = bus.mem_req && bus.mem_ack;
  assign rv_ok    = bus.mem_rvalid && (outstanding != '0);
  assign rv_stray = bus.mem_rvalid && (outstanding == '0);
  assign push     = (state == RUN) && rv_ok && !bus.fill_abort;

  assign bus.fill_ready = (state == IDLE);
  assign bus.fill_valid = (state == RUN) && !fifo_empty;
  assign pop            = bus.fill_valid && bus.fill_take;
  assign pop_last       = pop && (head_idx == '1) && !bus.fill_abort;

  assign bus.fill_data  = bus.fill_valid ? head_data : '0;
  assign bus.fill_index = bus.fill_valid ? head_idx : '0;
  assign bus.fill_last  = bus.fill_valid && (head_idx == '1);
  assign bus.fill_done  = fill_done_q;
  assign bus.err        = err_q;

  sdram_fill_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({bus.mem_rdata, ret_idx}),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    outstanding_nxt = outstanding;
    if (acked && !rv_ok)      outstanding_nxt = outstanding + CW'(1);
    else if (!acked && rv_ok) outstanding_nxt = outstanding - CW'(1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.fill_req) state_nxt = RUN;
      RUN: begin
        if (bus.fill_abort)  state_nxt = (outstanding_nxt != '0) ? DRAIN : IDLE;
        else if (pop_last)   state_nxt = IDLE;
      end
      DRAIN: if (outstanding_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_addr   <= '0;
      issue_idx   <= '0;
      ret_idx     <= '0;
      outstanding <= '0;
      fill_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      fill_done_q <= pop_last;
      if (rv_stray) err_q <= 1'b1;
      if (accept) begin
        base_addr <= {bus.fill_addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
        issue_idx <= '0;
        ret_idx   <= '0;
      end else begin
        if (acked) issue_idx <= issue_idx + (IDX_W+1)'(1);
        if (push)  ret_idx   <= ret_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdram_line_fill_sequencer.sv
// Self-checking bench: table of whole-line fills plus directed abort, error and reset sequences.
module tb_sdram_line_fill_sequencer;

  localparam int LW = 64;
  localparam int AW = 25;

  typedef struct {
    int          due;
    logic [15:0] d;
  } rd_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            lat;
    int            take_period;
    logic [AW-1:0] exp_base;
    int            exp_overlap;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sdram_line_fill_sequencer_if #(.LINE_WORDS(LW), .ADDR_W(AW)) bus ();

  sdram_line_fill_sequencer #(.LINE_WORDS(LW), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rv_lat = 2;
  int take_period = 0;
  int ack_cnt, beat_cnt, done_cnt, overlap_cnt;
  bit auto_mem = 1'b1;
  bit take_hold = 1'b0;
  bit chk_stream = 1'b0;
  bit chk_credit = 1'b0;
  logic req_drv = 1'b0, abort_drv = 1'b0, ack_drv = 1'b0, rv_drv = 1'b0;
  logic [AW-1:0] addr_drv = '0;
  logic [AW-1:0] exp_base = '0;
  rd_t  pend [$];
  vec_t vecs [5];

  function automatic logic [15:0] data_of(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5AC3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: observe state-driven outputs at the falling edge, then drive the inputs.
  task automatic cycle();
    logic        ack, rv, take;
    logic [15:0] rd;
    rd_t         r;
    @(negedge clk);
    if (bus.fill_done) begin
      done_cnt++;
      check("ready_with_done", 32'(bus.fill_ready), 32'd1);
    end
    ack = 1'b0;
    rv  = 1'b0;
    rd  = 16'h0;
    if (auto_mem) begin
      ack = bus.mem_req;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r  = pend.pop_front();
        rv = 1'b1;
        rd = r.d;
      end
    end else begin
      ack = ack_drv && bus.mem_req;
      rv  = rv_drv;
      rd  = 16'hDEAD;
    end
    if (ack) begin
      if (chk_stream) check("mem_addr", 32'(bus.mem_addr), 32'(exp_base + AW'(ack_cnt)));
      if (auto_mem) pend.push_back('{due: cyc + rv_lat, d: data_of(bus.mem_addr)});
      ack_cnt++;
    end
    if (ack && rv) overlap_cnt++;
    take = take_hold ? 1'b0 : ((take_period == 0) || (cyc % take_period != 0));
    if (bus.fill_valid && take) begin
      if (chk_stream) begin
        check("fill_index", 32'(bus.fill_index), 32'(beat_cnt));
        check("fill_data", 32'(bus.fill_data), 32'(data_of(exp_base + AW'(beat_cnt))));
        check("fill_last", 32'(bus.fill_last), 32'(beat_cnt == LW - 1));
      end
      beat_cnt++;
    end
    if (chk_credit) check("credit", 32'((ack_cnt - beat_cnt) <= 4), 32'd1);
    bus.mem_ack    = ack;
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rd;
    bus.fill_take  = take;
    bus.fill_req   = req_drv;
    bus.fill_addr  = addr_drv;
    bus.fill_abort = abort_drv;
    cyc++;
  endtask

  task automatic begin_fill(input logic [AW-1:0] addr, input int lat, input int tp,
                            input logic [AW-1:0] base, input string tag);
    auto_mem = 1'b1; rv_lat = lat; take_period = tp; exp_base = base; chk_stream = 1'b1;
    ack_cnt = 0; beat_cnt = 0; done_cnt = 0; overlap_cnt = 0;
    req_drv = 1'b1; addr_drv = addr;
    cycle();
    check({tag, ":ready_at_req"}, 32'(bus.fill_ready), 32'd1);
    req_drv = 1'b0;
  endtask

  task automatic finish_fill(input string tag, input int exp_overlap);
    int budget = 3000;
    while (done_cnt == 0 && budget > 0) begin
      cycle();
      budget--;
    end
    check({tag, ":no_timeout"}, 32'(budget > 0), 32'd1);
    repeat (6) cycle();
    check({tag, ":beats"}, 32'(beat_cnt), 32'(LW));
    check({tag, ":acks"}, 32'(ack_cnt), 32'(LW));
    check({tag, ":done_once"}, 32'(done_cnt), 32'd1);
    check({tag, ":ready_after"}, 32'(bus.fill_ready), 32'd1);
    check({tag, ":valid_after"}, 32'(bus.fill_valid), 32'd0);
    check({tag, ":err"}, 32'(bus.err), 32'd0);
    if (exp_overlap >= 0) check({tag, ":ack_rvalid_overlap"}, 32'(overlap_cnt), 32'(exp_overlap));
    chk_stream = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":fill_ready"}, 32'(bus.fill_ready), 32'd1);
    check({tag, ":fill_valid"}, 32'(bus.fill_valid), 32'd0);
    check({tag, ":fill_data"}, 32'(bus.fill_data), 32'd0);
    check({tag, ":fill_index"}, 32'(bus.fill_index), 32'd0);
    check({tag, ":fill_last"}, 32'(bus.fill_last), 32'd0);
    check({tag, ":fill_done"}, 32'(bus.fill_done), 32'd0);
    check({tag, ":mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, ":mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, ":err"}, 32'(bus.err), 32'd0);
  endtask

  task automatic idle_inputs();
    req_drv = 1'b0; abort_drv = 1'b0; ack_drv = 1'b0; rv_drv = 1'b0;
    bus.fill_req = 1'b0; bus.fill_abort = 1'b0; bus.fill_take = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.fill_addr = '0;
  endtask

  initial begin
    int budget;
    // base = fill_addr with the low 6 bits cleared; overlap = cycles with mem_ack and mem_rvalid together
    vecs[0] = '{addr: 25'h0012345, lat: 2, take_period: 0, exp_base: 25'h0012340, exp_overlap: 62};
    vecs[1] = '{addr: 25'h0000080, lat: 1, take_period: 0, exp_base: 25'h0000080, exp_overlap: 63};
    vecs[2] = '{addr: 25'h1FFFFFF, lat: 3, take_period: 3, exp_base: 25'h1FFFFC0, exp_overlap: -1};
    vecs[3] = '{addr: 25'h000003F, lat: 4, take_period: 2, exp_base: 25'h0000000, exp_overlap: -1};
    vecs[4] = '{addr: 25'h00ABCDE, lat: 1, take_period: 0, exp_base: 25'h00ABCC0, exp_overlap: 63};

    idle_inputs();

    // T1: asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1 check_reset_outputs("t1");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // T2 and T5 streams plus boundary addresses
    for (int i = 0; i < 5; i++) begin
      begin_fill(vecs[i].addr, vecs[i].lat, vecs[i].take_period, vecs[i].exp_base, $sformatf("vec%0d", i));
      finish_fill($sformatf("vec%0d", i), vecs[i].exp_overlap);
    end

    // T3: cache stalls; credits stop issue after four reads
    begin_fill(25'h0000200, 2, 0, 25'h0000200, "t3");
    take_hold = 1'b1;
    chk_credit = 1'b1;
    repeat (20) cycle();
    check("t3:acks_while_stalled", 32'(ack_cnt), 32'd4);
    check("t3:req_low_while_stalled", 32'(bus.mem_req), 32'd0);
    check("t3:valid_while_stalled", 32'(bus.fill_valid), 32'd1);
    take_hold = 1'b0;
    finish_fill("t3", -1);
    chk_credit = 1'b0;

    // T4: abort with two reads outstanding, one word buffered, and one request still unacked
    auto_mem = 1'b0; take_hold = 1'b1; chk_stream = 1'b0;
    ack_cnt = 0; beat_cnt = 0; done_cnt = 0;
    req_drv = 1'b1; addr_drv = 25'h0000100;
    cycle();
    req_drv = 1'b0; ack_drv = 1'b1;
    repeat (3) cycle();
    check("t4:acks", 32'(ack_cnt), 32'd3);
    ack_drv = 1'b0; rv_drv = 1'b1;
    cycle();
    rv_drv = 1'b0; abort_drv = 1'b1;
    cycle();
    check("t4:valid_in_abort_cycle", 32'(bus.fill_valid), 32'd1);
    check("t4:req_in_abort_cycle", 32'(bus.mem_req), 32'd1);
    abort_drv = 1'b0; rv_drv = 1'b1;
    cycle();
    check("t4:valid_after_abort", 32'(bus.fill_valid), 32'd0);
    check("t4:req_in_drain", 32'(bus.mem_req), 32'd0);
    check("t4:ready_in_drain", 32'(bus.fill_ready), 32'd0);
    cycle();
    check("t4:ready_at_last_rvalid", 32'(bus.fill_ready), 32'd0);
    rv_drv = 1'b0;
    cycle();
    check("t4:ready_after_drain", 32'(bus.fill_ready), 32'd1);
    check("t4:valid_after_drain", 32'(bus.fill_valid), 32'd0);
    check("t4:no_done", 32'(done_cnt), 32'd0);
    check("t4:err", 32'(bus.err), 32'd0);
    take_hold = 1'b0;

    // T5 tail: stray rvalid in IDLE sets a sticky error
    rv_drv = 1'b1;
    cycle();
    rv_drv = 1'b0;
    cycle();
    check("t5:err_set", 32'(bus.err), 32'd1);
    check("t5:stray_dropped", 32'(bus.fill_valid), 32'd0);
    repeat (5) cycle();
    check("t5:err_sticky", 32'(bus.err), 32'd1);
    check("t5:ready", 32'(bus.fill_ready), 32'd1);

    // T6: reset in the middle of a line, then a clean fill
    begin_fill(25'h0000400, 2, 0, 25'h0000400, "t6a");
    budget = 500;
    while (beat_cnt < 30 && budget > 0) begin
      cycle();
      budget--;
    end
    check("t6:reached_word30", 32'(budget > 0), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t6");
    idle_inputs();
    chk_stream = 1'b0;
    pend.delete();
    @(negedge clk);
    rst = 1'b0;
    begin_fill(25'h0000080, 2, 0, 25'h0000080, "t6b");
    finish_fill("t6b", 62);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
